// File: rtl/load_store_unit_if.sv
// Request/response and word-memory bus bundle for the load/store unit.
// master = requester plus memory model side, slave = the load/store unit.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

interface load_store_unit_if #(
    parameter int WORD_ADDR_BITS = `DATA_BITS - 2
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [2:0]                req_funct3;
    logic [31:0]               req_address;
    logic [31:0]               req_wdata;
    logic                      resp_valid;
    logic [31:0]               resp_rdata;
    logic                      resp_error;
    logic [WORD_ADDR_BITS-1:0] mem_address;
    logic [3:0]                mem_byteena;
    logic [31:0]               mem_data;
    logic                      mem_wren;
    logic [31:0]               mem_q;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata,
        output mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_byteena, mem_data, mem_wren
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata,
        input  mem_q,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store engine on a word-organised memory port.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two words.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module load_store_unit #(
    parameter int WORD_ADDR_BITS = `DATA_BITS - 2
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC0, DONE} state_t;
`endif

    state_t state, next;

    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [31:0] rdata_q;
    logic        err_q;

    function automatic logic [3:0] lanes(input logic [1:0] sz);
        unique case (sz)
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic legal(input logic w, input logic [2:0] f);
        if (w) legal = (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
        else   legal = (f != 3'b011) && (f[2:1] != 2'b11);
    endfunction

    logic [7:0]  mask_in;
    logic [7:0]  mask;
    logic        bad_in;
    logic [63:0] wshift;
    logic [31:0] lo_src;
    logic [31:0] hi_src;
    logic [63:0] joined;
    logic [31:0] ext;
    logic [WORD_ADDR_BITS-1:0] word_q;

    assign mask_in = {4'b0, lanes(bus.req_funct3[1:0])} << bus.req_address[1:0];
    assign mask    = {4'b0, lanes(f3_q[1:0])} << addr_q[1:0];
    assign wshift  = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign word_q  = addr_q[WORD_ADDR_BITS+1:2];

`ifdef MISALIGNED_SPLIT_EN
    assign bad_in = !legal(bus.req_write, bus.req_funct3);
`else
    assign bad_in = !legal(bus.req_write, bus.req_funct3) || (|mask_in[7:4]);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next            = state;
        bus.mem_address = '0;
        bus.mem_byteena = 4'b0;
        bus.mem_data    = 32'b0;
        bus.mem_wren    = 1'b0;
        bus.resp_valid  = 1'b0;
        lo_src          = lo_q;
        hi_src          = 32'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) next = bad_in ? DONE : ACC0;
            end
            ACC0: begin
                bus.mem_address = word_q;
                bus.mem_byteena = mask[3:0];
                bus.mem_data    = wshift[31:0];
                bus.mem_wren    = wr_q && (|mask[3:0]);
                lo_src          = bus.mem_q;
`ifdef MISALIGNED_SPLIT_EN
                next            = (|mask[7:4]) ? ACC1 : DONE;
`else
                next            = DONE;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ACC1: begin
                bus.mem_address = word_q + {{(WORD_ADDR_BITS-1){1'b0}}, 1'b1};
                bus.mem_byteena = mask[7:4];
                bus.mem_data    = wshift[63:32];
                bus.mem_wren    = wr_q && (|mask[7:4]);
                hi_src          = bus.mem_q;
                next            = DONE;
            end
`endif
            DONE: begin
                bus.resp_valid = 1'b1;
                next           = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Result is formed on the edge leaving the last access, so DONE only presents it.
    assign joined = {hi_src, lo_src} >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext = joined[31:0];
        unique case (f3_q[1:0])
            2'b00:   ext = {{24{!f3_q[2] && joined[7]}}, joined[7:0]};
            2'b01:   ext = {{16{!f3_q[2] && joined[15]}}, joined[15:0]};
            default: ext = joined[31:0];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_write;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_address;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACC0) lo_q <= bus.mem_q;
            if (next == DONE && state != DONE) begin
                if (state == IDLE) begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b1;
                end else begin
                    rdata_q <= wr_q ? 32'b0 : ext;
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = err_q;

endmodule
